day1_input_parser: RTL and testbench

//   Byte-stream front end for day1_puzzle: parses ASCII rotation lines ("L68\n", "R48\r\n")

---
 rtl/day1_input_parser.sv | 160 ++++++++++++++++
 tb/tb_day1_input_parser.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/day1_input_parser.sv
// ASCII rotation-line parser ("L68\n", "R48\r\n") feeding day1_puzzle's
// init/valid/ready command interface, one command in flight at a time.
module day1_input_parser #(
  parameter int WIDTH     = 16,
  parameter int START_POS = 50,
  parameter int DIAL_MAX  = 99
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             init,
  output logic             valid,
  input  logic             ready,
  output logic             rotation,
  output logic [WIDTH-1:0] rotate_amount,
  output logic [WIDTH-1:0] max_number,
  output logic [WIDTH-1:0] cmd_count,
  output logic [7:0]       err_count,
  output logic             overflow,
  output logic             done
);
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_DIR  = 3'd1;
  localparam logic [2:0] S_NUM  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_SKIP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_SP = 8'h20;
  localparam logic [7:0] C_L  = 8'h4C;
  localparam logic [7:0] C_R  = 8'h52;
  localparam logic [7:0] C_0  = 8'h30;
  localparam logic [7:0] C_9  = 8'h39;
  localparam logic [WIDTH+3:0] ACC_MAX = {4'b0000, {WIDTH{1'b1}}};

  logic [2:0]       r_state;
  logic             r_init;
  logic             r_rotation;
  logic [WIDTH-1:0] r_amount;
  logic [WIDTH-1:0] r_acc;
  logic             r_has_dig;
  logic             r_last;
  logic [WIDTH-1:0] r_cmd;
  logic [7:0]       r_err;
  logic             r_ovf;

  logic             w_fire;
  logic             w_is_dig;
  logic             w_is_eol;
  logic             w_is_sp;
  logic             w_is_dir;
  logic             w_err_inc;
  logic [WIDTH+3:0] w_prod;
  logic             w_acc_ovf;
  logic [WIDTH-1:0] w_acc_nx;

  assign in_ready      = (r_state == S_DIR) || (r_state == S_NUM) || (r_state == S_SKIP);
  assign valid         = (r_state == S_EMIT);
  assign done          = (r_state == S_DONE);
  assign init          = r_init;
  assign rotation      = r_rotation;
  assign rotate_amount = r_amount;
  assign max_number    = WIDTH'(DIAL_MAX);
  assign cmd_count     = r_cmd;
  assign err_count     = r_err;
  assign overflow      = r_ovf;

  assign w_fire   = in_valid && in_ready;
  assign w_is_dig = (in_data >= C_0) && (in_data <= C_9);
  assign w_is_eol = (in_data == C_LF) || (in_data == C_CR);
  assign w_is_sp  = (in_data == C_SP);
  assign w_is_dir = (in_data == C_L) || (in_data == C_R);

  // Four spare bits hold acc*10+9 for any acc, so saturation is a plain compare.
  assign w_prod    = ({4'b0000, r_acc} * (WIDTH+4)'(10)) + (WIDTH+4)'(in_data[3:0]);
  assign w_acc_ovf = (w_prod > ACC_MAX);
  assign w_acc_nx  = w_acc_ovf ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];

  // A direction that arrives with in_last is an incomplete line.
  always_comb begin
    w_err_inc = 1'b0;
    if (w_fire) begin
      case (r_state)
        S_DIR:   w_err_inc = w_is_dir ? in_last : !(w_is_eol || w_is_sp);
        S_NUM:   w_err_inc = !w_is_dig && !(w_is_eol && r_has_dig);
        default: w_err_inc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init     <= 1'b0;
      r_rotation <= 1'b0;
      r_amount   <= '0;
      r_acc      <= '0;
      r_has_dig  <= 1'b0;
      r_last     <= 1'b0;
      r_cmd      <= '0;
      r_err      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      case (r_state)
        S_INIT: begin
          if (!r_init) begin
            r_init   <= 1'b1;
            r_amount <= WIDTH'(START_POS);
          end else begin
            r_init  <= 1'b0;
            r_state <= S_DIR;
          end
        end
        S_DIR: if (w_fire) begin
          if (in_last) r_state <= S_DONE;
          else if (w_is_dir) begin
            r_rotation <= (in_data == C_R);
            r_acc      <= '0;
            r_has_dig  <= 1'b0;
            r_state    <= S_NUM;
          end else if (!(w_is_eol || w_is_sp)) r_state <= S_SKIP;
        end
        S_NUM: if (w_fire) begin
          if (w_is_dig) begin
            r_acc     <= w_acc_nx;
            r_has_dig <= 1'b1;
            if (w_acc_ovf) r_ovf <= 1'b1;
            if (in_last) begin
              r_amount <= w_acc_nx;
              r_last   <= 1'b1;
              r_state  <= S_EMIT;
            end
          end else if (w_is_eol && r_has_dig) begin
            r_amount <= r_acc;
            r_last   <= in_last;
            r_state  <= S_EMIT;
          end else if (in_last) r_state <= S_DONE;
          else if (w_is_eol)    r_state <= S_DIR;
          else                  r_state <= S_SKIP;
        end
        S_SKIP: if (w_fire) begin
          if (in_last)              r_state <= S_DONE;
          else if (in_data == C_LF) r_state <= S_DIR;
        end
        S_EMIT: if (ready) begin
          r_cmd   <= r_cmd + WIDTH'(1);
          r_state <= r_last ? S_DONE : S_DIR;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_day1_input_parser.sv
// Directed and randomized checks of day1_input_parser at WIDTH=16 and WIDTH=8,
// both instances fed the same byte stream and compared against a line-level model.
module tb_day1_input_parser;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       dir_rdy = 1'b1;
  logic       rnd_rdy = 1'b0;
  logic       rnd_mode = 1'b0;
  logic       ready;
  assign ready = rnd_mode ? rnd_rdy : dir_rdy;

  logic        in_ready16, init16, valid16, rot16, ovf16, done16;
  logic [15:0] amt16, max16, cnt16;
  logic [7:0]  err16;
  logic        in_ready8, init8, valid8, rot8, ovf8, done8;
  logic [7:0]  amt8, max8, cnt8, err8;

  day1_input_parser #(.WIDTH(16), .START_POS(50), .DIAL_MAX(99)) u16 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready16), .init(init16), .valid(valid16), .ready(ready), .rotation(rot16),
    .rotate_amount(amt16), .max_number(max16), .cmd_count(cnt16), .err_count(err16),
    .overflow(ovf16), .done(done16));

  day1_input_parser #(.WIDTH(8), .START_POS(50), .DIAL_MAX(99)) u8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready8), .init(init8), .valid(valid8), .ready(ready), .rotation(rot8),
    .rotate_amount(amt8), .max_number(max8), .cmd_count(cnt8), .err_count(err8),
    .overflow(ovf8), .done(done8));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int init_cnt = 0;
  int hold_err = 0;
  int q16[$];
  int q8[$];
  int e16[$];
  int e8[$];
  int m_q[$];
  int m_err;
  bit m_ovf;
  byte g_s[$];
  logic        pv16 = 1'b0;
  logic        prot = 1'b0;
  logic [15:0] pamt = 16'h0;

  function automatic int enc(input int o, input int r, input int a);
    return (o << 20) | (r << 16) | a;
  endfunction

  // Transfer log plus protocol watch: held command must not change, no bytes
  // taken while a command is pending, and both widths must agree on handshakes.
  always @(posedge clock) begin
    rnd_rdy <= 1'($urandom_range(0, 1));
    if (init16) init_cnt <= init_cnt + 1;
    if (!reset && valid16 && ready) q16.push_back(enc(int'(ovf16), int'(rot16), int'(amt16)));
    if (!reset && valid8 && ready) q8.push_back(enc(int'(ovf8), int'(rot8), int'(amt8)));
    if (!reset && ((pv16 && (!valid16 || rot16 !== prot || amt16 !== pamt)) ||
                   (valid16 && in_ready16) || (in_ready16 !== in_ready8) || (valid16 !== valid8)))
      hold_err <= hold_err + 1;
    pv16 <= valid16 && !ready && !reset;
    prot <= rot16;
    pamt <= amt16;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: split at LF, drop one trailing CR and leading spaces, then judge the line.
  function automatic void eval_line(input byte l0[$], input int w);
    byte    ln[$];
    longint v;
    longint mx;
    bit     good;
    ln = l0;
    mx = (longint'(1) << w) - 1;
    if (ln.size() > 0 && ln[ln.size()-1] == 8'h0D) void'(ln.pop_back());
    while (ln.size() > 0 && ln[0] == 8'h20) void'(ln.pop_front());
    if (ln.size() == 0) return;
    if (ln[0] != "L" && ln[0] != "R") begin m_err++; return; end
    if (ln.size() == 1) begin m_err++; return; end
    v = 0;
    good = 1'b1;
    for (int i = 1; i < ln.size(); i++) begin
      if (ln[i] >= "0" && ln[i] <= "9") begin
        v = v * 10 + longint'(ln[i] - "0");
        if (v > mx) begin v = mx; m_ovf = 1'b1; end
      end else begin
        good = 1'b0;
        break;
      end
    end
    if (!good) begin m_err++; return; end
    m_q.push_back(enc(int'(m_ovf), (ln[0] == "R") ? 1 : 0, int'(v)));
  endfunction

  task automatic run_model(input byte s[$], input int w);
    byte ln[$];
    m_q.delete();
    m_err = 0;
    m_ovf = 1'b0;
    foreach (s[i]) begin
      if (s[i] == 8'h0A) begin eval_line(ln, w); ln.delete(); end
      else ln.push_back(s[i]);
    end
    if (ln.size() > 0) eval_line(ln, w);
  endtask

  task automatic add_digits(input int n);
    for (int j = 0; j < n; j++) g_s.push_back(byte'(8'h30 + 8'($urandom_range(0, 9))));
  endtask

  task automatic gen_stream();
    int nl;
    g_s.delete();
    nl = $urandom_range(5, 9);
    for (int i = 0; i < nl; i++) begin
      int  t;
      byte d;
      t = $urandom_range(0, 6);
      d = ($urandom_range(0, 1) == 1) ? "R" : "L";
      case (t)
        0, 1, 6: begin
          if (t == 6) begin g_s.push_back(" "); g_s.push_back(" "); end
          g_s.push_back(d);
          add_digits($urandom_range(1, 5));
          if (t == 1) g_s.push_back(8'h0D);
          g_s.push_back(8'h0A);
        end
        2: g_s.push_back(8'h0A);
        3: begin g_s.push_back("Q"); add_digits(2); g_s.push_back(8'h0A); end
        4: begin g_s.push_back(d); g_s.push_back(8'h0A); end
        default: begin
          g_s.push_back(d); add_digits(1); g_s.push_back("x"); add_digits(1); g_s.push_back(8'h0A);
        end
      endcase
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the byte is taken.
  task automatic send_byte(input byte b, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    for (int k = 0; k < 400 && !ok; k++) begin
      if (in_ready16) begin @(posedge clock); ok = 1'b1; end
      else @(negedge clock);
    end
    if (!ok) chk("byte_accept_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_q(input byte s[$]);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], i == s.size() - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000; k++) begin
      if (done16) break;
      @(negedge clock);
    end
    chk("done16", longint'(done16), 1);
    chk("done8", longint'(done8), 1);
    chk("in_ready_after_done", longint'(in_ready16), 0);
    chk("valid_after_done", longint'(valid16), 0);
  endtask

  task automatic do_reset();
    int ic0;
    ic0 = init_cnt;
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clock);
    chk("rst_valid", longint'(valid16), 0);
    chk("rst_in_ready", longint'(in_ready16), 0);
    chk("rst_init", longint'(init16), 0);
    chk("rst_done", longint'(done16), 0);
    chk("rst_cmd", longint'(cnt16), 0);
    chk("rst_err", longint'(err16), 0);
    chk("rst_ovf", longint'(ovf16), 0);
    chk("rst_amount", longint'(amt16), 0);
    chk("rst_rotation", longint'(rot16), 0);
    chk("rst_max16", longint'(max16), 99);
    chk("rst_max8", longint'(max8), 99);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10 && !init16; k++) @(negedge clock);
    chk("init_pulse", longint'(init16), 1);
    chk("init_amount16", longint'(amt16), 50);
    chk("init_amount8", longint'(amt8), 50);
    chk("init_in_ready", longint'(in_ready16), 0);
    chk("init_valid", longint'(valid16), 0);
    repeat (3) @(negedge clock);
    chk("init_once", longint'(init_cnt - ic0), 1);
    chk("init_low", longint'(init16), 0);
  endtask

  task automatic chk_cmds(input string tag, input int b16, input int b8);
    chk({tag, "_n16"}, longint'(q16.size() - b16), longint'(e16.size()));
    chk({tag, "_n8"}, longint'(q8.size() - b8), longint'(e8.size()));
    for (int i = 0; i < e16.size(); i++)
      if (b16 + i < q16.size()) chk({tag, "_cmd16"}, longint'(q16[b16+i]), longint'(e16[i]));
    for (int i = 0; i < e8.size(); i++)
      if (b8 + i < q8.size()) chk({tag, "_cmd8"}, longint'(q8[b8+i]), longint'(e8[i]));
  endtask

  initial begin
    int b16;
    int b8;
    int h0;
    int xerr;
    bit xovf;

    // 1: three well-formed lines, last on final LF
    dir_rdy = 1'b1;
    do_reset();
    b16 = q16.size(); b8 = q8.size();
    send_str("L68\nL30\nR48\n", 1'b1);
    wait_done();
    e16.delete(); e16.push_back(enc(0,0,68)); e16.push_back(enc(0,0,30)); e16.push_back(enc(0,1,48));
    e8 = e16;
    chk_cmds("t1", b16, b8);
    chk("t1_cmd_count", longint'(cnt16), 3);
    chk("t1_err", longint'(err16), 0);

    // 2: CR terminator with ready held low for four cycles
    do_reset();
    dir_rdy = 1'b0;
    b16 = q16.size(); b8 = q8.size();
    send_byte("R", 1'b0);
    send_byte("5", 1'b0);
    send_byte(8'h0D, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_hold_valid", longint'(valid16), 1);
      chk("t2_hold_rot", longint'(rot16), 1);
      chk("t2_hold_amt", longint'(amt16), 5);
      chk("t2_hold_in_ready", longint'(in_ready16), 0);
      @(negedge clock);
    end
    dir_rdy = 1'b1;
    @(negedge clock);
    chk("t2_valid_dropped", longint'(valid16), 0);
    chk("t2_cmd_count", longint'(cnt16), 1);
    send_str("\n", 1'b1);
    wait_done();
    e16.delete(); e16.push_back(enc(0,1,5));
    e8 = e16;
    chk_cmds("t2", b16, b8);
    chk("t2_cmd_final", longint'(cnt16), 1);

    // 3: bad first char and direction-only line are dropped
    do_reset();
    b16 = q16.size(); b8 = q8.size();
    send_str("X12\nL\nR7\n", 1'b1);
    wait_done();
    e16.delete(); e16.push_back(enc(0,1,7));
    e8 = e16;
    chk_cmds("t3", b16, b8);
    chk("t3_err", longint'(err16), 2);
    chk("t3_cmd_count", longint'(cnt16), 1);

    // 4: saturation at WIDTH=8, no saturation at WIDTH=16
    do_reset();
    b16 = q16.size(); b8 = q8.size();
    send_str("R300\nL255\n", 1'b1);
    wait_done();
    e16.delete(); e16.push_back(enc(0,1,300)); e16.push_back(enc(0,0,255));
    e8.delete();  e8.push_back(enc(1,1,255));  e8.push_back(enc(1,0,255));
    chk_cmds("t4", b16, b8);
    chk("t4_ovf8", longint'(ovf8), 1);
    chk("t4_ovf16", longint'(ovf16), 0);

    // 5: in_last on a digit with no newline
    do_reset();
    b16 = q16.size(); b8 = q8.size();
    send_str("L9", 1'b1);
    wait_done();
    e16.delete(); e16.push_back(enc(0,0,9));
    e8 = e16;
    chk_cmds("t5", b16, b8);
    chk("t5_cmd_count", longint'(cnt16), 1);

    // 6: reset while a command is pending
    do_reset();
    dir_rdy = 1'b0;
    b16 = q16.size(); b8 = q8.size();
    send_str("Q\nR12\n", 1'b0);
    chk("t6_pending_valid", longint'(valid16), 1);
    chk("t6_pending_err", longint'(err16), 1);
    do_reset();
    dir_rdy = 1'b1;
    send_str("L3\n", 1'b1);
    wait_done();
    e16.delete(); e16.push_back(enc(0,0,3));
    e8 = e16;
    chk_cmds("t6", b16, b8);
    chk("t6_cmd_count", longint'(cnt16), 1);
    chk("t6_err", longint'(err16), 0);

    // Randomized streams with random ready, against the line-level model
    for (int r = 0; r < 6; r++) begin
      rnd_mode = 1'b1;
      gen_stream();
      run_model(g_s, 16);
      e16 = m_q; xerr = m_err; xovf = m_ovf;
      run_model(g_s, 8);
      e8 = m_q;
      do_reset();
      h0 = hold_err;
      b16 = q16.size(); b8 = q8.size();
      send_q(g_s);
      wait_done();
      chk_cmds("rnd", b16, b8);
      chk("rnd_err16", longint'(err16), longint'(xerr));
      chk("rnd_err8", longint'(err8), longint'(m_err));
      chk("rnd_ovf16", longint'(ovf16), longint'(xovf));
      chk("rnd_ovf8", longint'(ovf8), longint'(m_ovf));
      chk("rnd_cnt16", longint'(cnt16), longint'(e16.size()));
      chk("rnd_cnt8", longint'(cnt8), longint'(e8.size()));
      chk("rnd_protocol", longint'(hold_err - h0), 0);
      rnd_mode = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
